// File: rtl/pacman_pkg.sv
// Shared Pac-Man maze types: directions, ghost mover states and the tile-step helper
// used by the mover and by the targeting stages.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_U = 2'b00,
    DIR_R = 2'b01,
    DIR_D = 2'b10,
    DIR_L = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    HOME,
    DECIDE,
    MOVING
  } mover_state_t;

  // Wide enough for any maze coordinate; callers truncate to their own width,
  // which keeps the arithmetic modular at the caller's width.
  localparam int COORD_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } tile_t;

  function automatic tile_t step_pos(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y,
                                     input dir_t               dir);
    tile_t t;
    t.x = x;
    t.y = y;
    unique case (dir)
      DIR_U: t.y = y - COORD_W'(1);
      DIR_D: t.y = y + COORD_W'(1);
      DIR_R: t.x = x + COORD_W'(1);
      DIR_L: t.x = x - COORD_W'(1);
      default: ;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ghost_mover.sv
// Ghost tile/sub-tile position tracker with HOME/DECIDE/MOVING control.
// Optional `GHOST_TUNNEL_WRAP_EN lets the ghost wrap through the left/right maze edges.
module ghost_mover
  import pacman_pkg::*;
#(
  parameter int X_BITS    = 5,
  parameter int Y_BITS    = 5,
  parameter int MAZE_W    = 28,
  parameter int SUB_STEPS = 8,
  parameter int INIT_X    = 13,
  parameter int INIT_Y    = 14
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         update,
  input  logic                         start,
  input  logic                         respawn,
  input  logic [1:0]                   dirToMove,
  input  logic                         canMoveU,
  input  logic                         canMoveR,
  input  logic                         canMoveD,
  input  logic                         canMoveL,
  output logic [X_BITS-1:0]            ghostPosX,
  output logic [Y_BITS-1:0]            ghostPosY,
  output logic [$clog2(SUB_STEPS)-1:0] subOffset,
  output logic [1:0]                   curDir,
  output logic                         dirReq,
  output logic                         moving,
  output logic                         stalled
);

  localparam int SUB_W = $clog2(SUB_STEPS);
  localparam logic [X_BITS-1:0] X_HOME = X_BITS'(INIT_X);
  localparam logic [Y_BITS-1:0] Y_HOME = Y_BITS'(INIT_Y);
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(MAZE_W - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(SUB_STEPS - 1);

  mover_state_t      state_q, state_d;
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  dir_t              dir_q, dir_d;
  logic              req_q, req_d;
  logic              mov_q, mov_d;
  logic              stl_q, stl_d;

  logic [3:0]        can_move;
  logic [3:0]        legal;
  tile_t             nxt;
  logic [X_BITS-1:0] nxt_x;
  logic [Y_BITS-1:0] nxt_y;

  assign can_move = {canMoveL, canMoveD, canMoveR, canMoveU};

  // Direction legality: wall flag, plus the maze side edges unless tunnels wrap.
  always_comb begin
    legal = can_move;
`ifndef GHOST_TUNNEL_WRAP_EN
    if (x_q == '0)    legal[DIR_L] = 1'b0;
    if (x_q == X_LAST) legal[DIR_R] = 1'b0;
`endif
  end

  always_comb begin
    nxt   = step_pos(COORD_W'(x_q), COORD_W'(y_q), dir_q);
    nxt_x = X_BITS'(nxt.x);
    nxt_y = Y_BITS'(nxt.y);
`ifdef GHOST_TUNNEL_WRAP_EN
    if (dir_q == DIR_L && x_q == '0)     nxt_x = X_LAST;
    if (dir_q == DIR_R && x_q == X_LAST) nxt_x = '0;
`endif
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sub_d   = sub_q;
    dir_d   = dir_q;
    req_d   = 1'b0;
    mov_d   = mov_q;
    stl_d   = stl_q;
    if (respawn) begin
      state_d = HOME;
      x_d     = X_HOME;
      y_d     = Y_HOME;
      sub_d   = '0;
      dir_d   = DIR_U;
      mov_d   = 1'b0;
      stl_d   = 1'b0;
    end else begin
      unique case (state_q)
        HOME: begin
          if (start) begin
            state_d = DECIDE;
            req_d   = 1'b1;
          end
        end
        DECIDE: begin
          if (update) begin
            if (legal[dirToMove] || legal[dir_q]) begin
              // Requested direction wins; otherwise keep going straight.
              if (legal[dirToMove]) dir_d = dir_t'(dirToMove);
              sub_d   = SUB_W'(1);
              state_d = MOVING;
              mov_d   = 1'b1;
              stl_d   = 1'b0;
            end else begin
              stl_d = 1'b1;
            end
          end
        end
        MOVING: begin
          if (update) begin
            if (sub_q == SUB_LAST) begin
              x_d     = nxt_x;
              y_d     = nxt_y;
              sub_d   = '0;
              state_d = DECIDE;
              req_d   = 1'b1;
              mov_d   = 1'b0;
            end else begin
              sub_d = sub_q + SUB_W'(1);
            end
          end
        end
        default: state_d = HOME;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HOME;
      x_q     <= X_HOME;
      y_q     <= Y_HOME;
      sub_q   <= '0;
      dir_q   <= DIR_U;
      req_q   <= 1'b0;
      mov_q   <= 1'b0;
      stl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sub_q   <= sub_d;
      dir_q   <= dir_d;
      req_q   <= req_d;
      mov_q   <= mov_d;
      stl_q   <= stl_d;
    end
  end

  assign ghostPosX = x_q;
  assign ghostPosY = y_q;
  assign subOffset = sub_q;
  assign curDir    = dir_q;
  assign dirReq    = req_q;
  assign moving    = mov_q;
  assign stalled   = stl_q;

endmodule

// File: tb/tb_ghost_mover.sv
// Scoreboard bench for ghost_mover: expected snapshots are queued with each stimulus
// and popped when the registered outputs are sampled after the edge.
module tb_ghost_mover;

  localparam int SUB = 8;

  logic       clk = 1'b0;
  logic       reset, update, start, respawn;
  logic [1:0] dirToMove;
  logic       canMoveU, canMoveR, canMoveD, canMoveL;
  logic [4:0] ghostPosX, ghostPosY;
  logic [2:0] subOffset;
  logic [1:0] curDir;
  logic       dirReq, moving, stalled;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [2:0] sub;
    logic [1:0] dir;
    logic       mv;
    logic       st;
    logic       rq;
  } snap_t;

  snap_t exp_q[$];
  snap_t got, e;
  int    n_vec = 0;
  int    n_err = 0;

  ghost_mover dut (
    .clk(clk), .reset(reset), .update(update), .start(start), .respawn(respawn),
    .dirToMove(dirToMove), .canMoveU(canMoveU), .canMoveR(canMoveR),
    .canMoveD(canMoveD), .canMoveL(canMoveL), .ghostPosX(ghostPosX),
    .ghostPosY(ghostPosY), .subOffset(subOffset), .curDir(curDir),
    .dirReq(dirReq), .moving(moving), .stalled(stalled)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(int x, int y, int sub, int dir, bit mv, bit st, bit rq);
    snap_t s;
    s.x = 5'(x); s.y = 5'(y); s.sub = 3'(sub); s.dir = 2'(dir);
    s.mv = mv; s.st = st; s.rq = rq;
    return s;
  endfunction

  function automatic snap_t snap();
    snap_t s;
    s.x = ghostPosX; s.y = ghostPosY; s.sub = subOffset; s.dir = curDir;
    s.mv = moving; s.st = stalled; s.rq = dirReq;
    return s;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input bit u, input bit r, input bit d, input bit l);
    canMoveU = u; canMoveR = r; canMoveD = d; canMoveL = l;
  endtask

  // Queue the expected snapshots of one full tile traversal from (x0,y0) to (x1,y1).
  task automatic push_tile(input int dir, input int x0, input int y0, input int x1, input int y1);
    for (int k = 0; k < SUB; k++)
      if (k == SUB - 1) exp_q.push_back(mk(x1, y1, 0, dir, 0, 0, 1));
      else              exp_q.push_back(mk(x0, y0, k + 1, dir, 1, 0, 0));
  endtask

  task automatic test_reset();
    reset = 1'b0; update = 0; start = 0; respawn = 0; dirToMove = 2'd0;
    set_flags(0, 0, 0, 0);
    exp_q.push_back(mk(13, 14, 0, 0, 0, 0, 0));
    repeat (2) cyc();
    got = snap(); e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_err++; $display("FAIL reset_state: got %p want %p", got, e); end
    reset = 1'b1;
    cyc();
    start = 1; cyc(); start = 0;
    dirToMove = 2'd1; set_flags(0, 1, 0, 0);
    update = 1; repeat (3) cyc(); update = 0;
    exp_q.push_back(mk(13, 14, 3, 1, 1, 0, 0));
    got = snap(); e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_err++; $display("FAIL pre_reset_move: got %p want %p", got, e); end
    exp_q.push_back(mk(13, 14, 0, 0, 0, 0, 0));
    #2 reset = 1'b0;
    #1;
    got = snap(); e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_err++; $display("FAIL async_reset: got %p want %p", got, e); end
    cyc();
    reset = 1'b1;
    set_flags(0, 0, 0, 0);
    cyc();
  endtask

  task automatic test_move_right();
    exp_q.push_back(mk(13, 14, 0, 0, 0, 0, 0));
    update = 1; cyc(); update = 0;
    got = snap(); e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_err++; $display("FAIL home_tick_ignored: got %p want %p", got, e); end
    exp_q.push_back(mk(13, 14, 0, 0, 0, 0, 1));
    exp_q.push_back(mk(13, 14, 0, 0, 0, 0, 0));
    start = 1; cyc(); start = 0;
    got = snap(); e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_err++; $display("FAIL start_dirreq: got %p want %p", got, e); end
    cyc();
    got = snap(); e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_err++; $display("FAIL dirreq_one_cycle: got %p want %p", got, e); end
    dirToMove = 2'd1; set_flags(0, 1, 0, 0);
    push_tile(1, 13, 14, 14, 14);
    for (int k = 0; k < SUB; k++) begin
      update = 1; cyc();
      got = snap(); e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL move_right[%0d]: got %p want %p", k, got, e); end
    end
    update = 0;
  endtask

  task automatic test_fallback();
    dirToMove = 2'd0; set_flags(1, 0, 0, 0);
    push_tile(0, 14, 14, 14, 13);
    dirToMove = 2'd3; set_flags(1, 0, 0, 0);
    push_tile(0, 14, 13, 14, 12);
    for (int k = 0; k < 2 * SUB; k++) begin
      if (k < SUB) dirToMove = 2'd0; else dirToMove = 2'd3;
      update = 1; cyc();
      got = snap(); e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL fallback[%0d]: got %p want %p", k, got, e); end
    end
    update = 0;
  endtask

  task automatic test_stall();
    dirToMove = 2'd0; set_flags(0, 0, 0, 0);
    exp_q.push_back(mk(14, 12, 0, 0, 0, 1, 0));
    exp_q.push_back(mk(14, 12, 0, 0, 0, 1, 0));
    for (int k = 0; k < 2; k++) begin
      update = 1; cyc();
      got = snap(); e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL stall[%0d]: got %p want %p", k, got, e); end
    end
    dirToMove = 2'd2; set_flags(0, 0, 1, 0);
    push_tile(2, 14, 12, 14, 13);
    for (int k = 0; k < SUB; k++) begin
      update = 1; cyc();
      got = snap(); e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL unstall[%0d]: got %p want %p", k, got, e); end
    end
    update = 0;
  endtask

  task automatic test_x_edge();
    dirToMove = 2'd3; set_flags(0, 0, 0, 1);
    for (int t = 1; t <= 14; t++) push_tile(3, 15 - t, 13, 14 - t, 13);
    for (int k = 0; k < 14 * SUB; k++) begin
      update = 1; cyc();
      got = snap(); e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL walk_left[%0d]: got %p want %p", k, got, e); end
    end
`ifdef GHOST_TUNNEL_WRAP_EN
    push_tile(3, 0, 13, 27, 13);
    for (int k = 0; k < SUB; k++) begin
      update = 1; cyc();
      got = snap(); e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL tunnel_wrap[%0d]: got %p want %p", k, got, e); end
    end
`else
    exp_q.push_back(mk(0, 13, 0, 3, 0, 1, 0));
    update = 1; cyc();
    got = snap(); e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_err++; $display("FAIL edge_block: got %p want %p", got, e); end
`endif
    update = 0;
  endtask

  task automatic test_respawn();
    exp_q.push_back(mk(13, 14, 0, 0, 0, 0, 0));
    respawn = 1; cyc(); respawn = 0;
    got = snap(); e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_err++; $display("FAIL respawn_home: got %p want %p", got, e); end
    start = 1; cyc(); start = 0;
    dirToMove = 2'd0; set_flags(1, 0, 0, 0);
    update = 1; repeat (5) cyc(); update = 0;
    exp_q.push_back(mk(13, 13 + 1, 5, 0, 1, 0, 0));
    got = snap(); e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_err++; $display("FAIL mid_tile_sub5: got %p want %p", got, e); end
    exp_q.push_back(mk(13, 14, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(13, 14, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(13, 14, 0, 0, 0, 0, 0));
    respawn = 1; update = 1; cyc(); update = 0;
    got = snap(); e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_err++; $display("FAIL respawn_over_update: got %p want %p", got, e); end
    start = 1; cyc(); start = 0; respawn = 0;
    got = snap(); e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_err++; $display("FAIL respawn_over_start: got %p want %p", got, e); end
    update = 1; cyc(); update = 0;
    got = snap(); e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_err++; $display("FAIL home_tick_after_respawn: got %p want %p", got, e); end
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_fallback();
    test_stall();
    test_x_edge();
    test_respawn();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
